// File: rtl/illm_row_deser.sv
// Row deserializer for the Loeffler IDCT row stage.
// Gathers eight coefficient tokens and presents them as one row.
module illm_row_deser #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] s_d,
  input  logic         s_v,
  input  logic         s_e,
  output logic         s_b,
  output logic [W-1:0] a0_d,
  output logic         a0_v,
  output logic         a0_e,
  input  logic         a0_b,
  output logic [W-1:0] a1_d,
  output logic         a1_v,
  output logic         a1_e,
  input  logic         a1_b,
  output logic [W-1:0] a2_d,
  output logic         a2_v,
  output logic         a2_e,
  input  logic         a2_b,
  output logic [W-1:0] a3_d,
  output logic         a3_v,
  output logic         a3_e,
  input  logic         a3_b,
  output logic [W-1:0] a4_d,
  output logic         a4_v,
  output logic         a4_e,
  input  logic         a4_b,
  output logic [W-1:0] a5_d,
  output logic         a5_v,
  output logic         a5_e,
  input  logic         a5_b,
  output logic [W-1:0] a6_d,
  output logic         a6_v,
  output logic         a6_e,
  input  logic         a6_b,
  output logic [W-1:0] a7_d,
  output logic         a7_v,
  output logic         a7_e,
  input  logic         a7_b,
  output logic         err
);

  typedef enum logic [1:0] {
    COLLECT,
    EMIT,
    EOSF,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_nxt;
  logic [2:0]     r_idx;
  logic           r_pend;
  logic           r_v;
  logic           r_e;
  logic           r_err;
  logic [W-1:0]   r_slot [8];
  logic           w_rdy;
  logic [7:0]     w_b;

  assign w_b = {a7_b, a6_b, a5_b, a4_b,
                a3_b, a2_b, a1_b, a0_b};
  // The row moves only when every consumer is ready.
  assign w_rdy = ~|w_b;

  assign s_b = (r_state != COLLECT);
  assign err = r_err;

  assign a0_d = r_slot[0];
  assign a1_d = r_slot[1];
  assign a2_d = r_slot[2];
  assign a3_d = r_slot[3];
  assign a4_d = r_slot[4];
  assign a5_d = r_slot[5];
  assign a6_d = r_slot[6];
  assign a7_d = r_slot[7];

  assign a0_v = r_v;
  assign a1_v = r_v;
  assign a2_v = r_v;
  assign a3_v = r_v;
  assign a4_v = r_v;
  assign a5_v = r_v;
  assign a6_v = r_v;
  assign a7_v = r_v;

  assign a0_e = r_e;
  assign a1_e = r_e;
  assign a2_e = r_e;
  assign a3_e = r_e;
  assign a4_e = r_e;
  assign a5_e = r_e;
  assign a6_e = r_e;
  assign a7_e = r_e;

  always_ff @(posedge clock) begin
    if (reset) r_state <= COLLECT;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      COLLECT: begin
        if (s_v) begin
          if (s_e)
            w_nxt = (r_idx == 3'd0) ? EOSF : EMIT;
          else if (r_idx == 3'd7)
            w_nxt = EMIT;
        end
      end
      EMIT: begin
        if (w_rdy)
          w_nxt = r_pend ? EOSF : COLLECT;
      end
      EOSF: begin
        if (w_rdy) w_nxt = DONE;
      end
      DONE:    w_nxt = DONE;
      default: w_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx  <= '0;
      r_pend <= 1'b0;
      r_v    <= 1'b0;
      r_e    <= 1'b0;
      r_err  <= 1'b0;
      for (int k = 0; k < 8; k++)
        r_slot[k] <= '0;
    end else begin
      unique case (r_state)
        COLLECT: begin
          if (s_v && !s_e) begin
            r_slot[r_idx] <= s_d;
            if (r_idx == 3'd7) r_v <= 1'b1;
            else r_idx <= r_idx + 3'd1;
          end else if (s_v && (r_idx == 3'd0)) begin
            for (int k = 0; k < 8; k++)
              r_slot[k] <= '0;
            r_v <= 1'b1;
            r_e <= 1'b1;
          end else if (s_v) begin
            // Truncated row: pad the tail, send it, then EOS.
            for (int k = 0; k < 8; k++)
              if (3'(k) >= r_idx) r_slot[k] <= '0;
            r_err  <= 1'b1;
            r_pend <= 1'b1;
            r_v    <= 1'b1;
          end
        end
        EMIT: begin
          if (w_rdy) begin
            r_idx <= '0;
            if (r_pend) begin
              r_pend <= 1'b0;
              r_e    <= 1'b1;
              for (int k = 0; k < 8; k++)
                r_slot[k] <= '0;
            end else begin
              r_v <= 1'b0;
            end
          end
        end
        EOSF: begin
          if (w_rdy) begin
            r_v <= 1'b0;
            r_e <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_illm_row_deser.sv
// Directed bench for illm_row_deser.
// Rows, backpressure, EOS paths, reset and a streaming soak.
module tb_illm_row_deser;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] s_d;
  logic        s_v;
  logic        s_e;
  logic        s_b;
  logic [15:0] ad [8];
  logic [7:0]  av;
  logic [7:0]  ae;
  logic [7:0]  ab;
  logic        err;

  int errs = 0;
  int checks = 0;

  always #5 clock = ~clock;

  illm_row_deser #(.W(16)) dut (
    .clock(clock), .reset(reset),
    .s_d(s_d), .s_v(s_v), .s_e(s_e), .s_b(s_b),
    .a0_d(ad[0]), .a0_v(av[0]), .a0_e(ae[0]), .a0_b(ab[0]),
    .a1_d(ad[1]), .a1_v(av[1]), .a1_e(ae[1]), .a1_b(ab[1]),
    .a2_d(ad[2]), .a2_v(av[2]), .a2_e(ae[2]), .a2_b(ab[2]),
    .a3_d(ad[3]), .a3_v(av[3]), .a3_e(ae[3]), .a3_b(ab[3]),
    .a4_d(ad[4]), .a4_v(av[4]), .a4_e(ae[4]), .a4_b(ab[4]),
    .a5_d(ad[5]), .a5_v(av[5]), .a5_e(ae[5]), .a5_b(ab[5]),
    .a6_d(ad[6]), .a6_v(av[6]), .a6_e(ae[6]), .a6_b(ab[6]),
    .a7_d(ad[7]), .a7_v(av[7]), .a7_e(ae[7]), .a7_b(ab[7]),
    .err(err)
  );

  function automatic logic [127:0] flat();
    logic [127:0] f;
    for (int k = 0; k < 8; k++)
      f[k*16 +: 16] = ad[k];
    return f;
  endfunction

  function automatic logic [127:0] seq_row(input logic [15:0] base);
    logic [127:0] f;
    for (int k = 0; k < 8; k++)
      f[k*16 +: 16] = base + 16'(k);
    return f;
  endfunction

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input logic e);
    logic ok;
    int n;
    s_d = d;
    s_e = e;
    s_v = 1'b1;
    n = 0;
    do begin
      ok = !s_b;
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) check("send_timeout", 128'(n), 128'(0));
    s_v = 1'b0;
    s_e = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [127:0] exp;
    int rows;
    int acc_n;
    int cyc;
    logic acc;
    logic xfer;

    reset = 1'b0;
    s_d = '0;
    s_v = 1'b0;
    s_e = 1'b0;
    ab = '0;
    do_reset();
    check("rst_v", 128'(av), 128'(0));
    check("rst_e", 128'(ae), 128'(0));
    check("rst_d", flat(), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_sb", 128'(s_b), 128'(0));

    for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
    check("r1_v", 128'(av), 128'hff);
    check("r1_d", flat(), seq_row(16'd1));
    check("r1_sb", 128'(s_b), 128'(1));
    check("r1_e", 128'(ae), 128'(0));
    send(16'd9, 1'b0);
    check("r1_done_v", 128'(av), 128'(0));
    check("r1_done_sb", 128'(s_b), 128'(0));
    for (int i = 10; i <= 15; i++) send(16'(i), 1'b0);
    ab = 8'h08;
    send(16'd16, 1'b0);
    for (int c = 0; c < 5; c++) begin
      check("bp_v", 128'(av), 128'hff);
      check("bp_d", flat(), seq_row(16'd9));
      check("bp_sb", 128'(s_b), 128'(1));
      tick();
    end
    ab = 8'h00;
    check("bp_last_v", 128'(av), 128'hff);
    tick();
    check("bp_xfer_v", 128'(av), 128'(0));
    check("bp_xfer_sb", 128'(s_b), 128'(0));

    for (int i = 0; i < 5; i++) send(16'h50 + 16'(i), 1'b0);
    do_reset();
    check("mrst_v", 128'(av), 128'(0));
    check("mrst_sb", 128'(s_b), 128'(0));
    check("mrst_d", flat(), 128'(0));
    for (int i = 0; i < 8; i++) send(16'h20 + 16'(i), 1'b0);
    check("mrst_row_v", 128'(av), 128'hff);
    check("mrst_row_d", flat(), seq_row(16'h20));
    tick();
    check("mrst_row_xfer", 128'(av), 128'(0));

    rows = 0;
    acc_n = 0;
    cyc = 0;
    s_e = 1'b0;
    s_v = 1'b1;
    s_d = 16'h100;
    while (rows < 100 && cyc < 5000) begin
      ab = $urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(0, 255));
      acc = !s_b;
      xfer = (av == 8'hff) && (ab == 8'h00);
      if (av != 8'h00 && av != 8'hff)
        check("rnd_av_split", 128'(av), 128'hff);
      if (xfer) begin
        check("rnd_row", flat(), seq_row(16'h100 + 16'(rows * 8)));
        rows++;
      end
      tick();
      cyc++;
      if (acc) begin
        acc_n++;
        s_d = 16'h100 + 16'(acc_n);
      end
    end
    check("rnd_rows", 128'(rows), 128'(100));
    s_v = 1'b0;
    ab = 8'h00;
    do_reset();

    for (int i = 0; i < 8; i++) send(16'h10 + 16'(i), 1'b0);
    check("eos_row_d", flat(), seq_row(16'h10));
    send(16'h0, 1'b1);
    check("eos_v", 128'(av), 128'hff);
    check("eos_e", 128'(ae), 128'hff);
    check("eos_d", flat(), 128'(0));
    check("eos_err", 128'(err), 128'(0));
    tick();
    check("done_v", 128'(av), 128'(0));
    check("done_e", 128'(ae), 128'(0));
    check("done_sb", 128'(s_b), 128'(1));
    tick();
    tick();
    check("done_sb2", 128'(s_b), 128'(1));
    check("done_err", 128'(err), 128'(0));
    do_reset();

    send(16'hA, 1'b0);
    send(16'hB, 1'b0);
    send(16'hC, 1'b0);
    check("pad_pre_v", 128'(av), 128'(0));
    send(16'h0, 1'b1);
    exp = '0;
    exp[15:0] = 16'hA;
    exp[31:16] = 16'hB;
    exp[47:32] = 16'hC;
    check("pad_v", 128'(av), 128'hff);
    check("pad_e", 128'(ae), 128'(0));
    check("pad_d", flat(), exp);
    check("pad_err", 128'(err), 128'(1));
    check("pad_sb", 128'(s_b), 128'(1));
    tick();
    check("pad_eos_v", 128'(av), 128'hff);
    check("pad_eos_e", 128'(ae), 128'hff);
    check("pad_eos_d", flat(), 128'(0));
    tick();
    check("pad_done_v", 128'(av), 128'(0));
    check("pad_done_sb", 128'(s_b), 128'(1));
    check("pad_done_err", 128'(err), 128'(1));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
